// File: rtl/traffic_sensor_in.sv
// rtl/traffic_sensor_in.sv - debounced, edge-detected, request-latched TA/TB car sensors
module traffic_sensor_chan #(
    parameter int DB_CYCLES = 40000,
    parameter int CNT_W     = 16,
    parameter int LATCH     = 1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       pin_n,
    input  logic [2:0] lt,
    output logic       t,
    output logic       evt,
    output logic [7:0] count
);

    localparam logic [CNT_W-1:0] DB_LAST = CNT_W'(DB_CYCLES - 1);

    logic             s1;
    logic             s2;
    logic             stable;
    logic [CNT_W-1:0] cnt;
    logic [2:0]       lt_s1;
    logic [2:0]       lt_s;
    logic             req;

    logic             accept;
    logic             fall;
    logic             stable_nxt;
    logic             served;
    logic             req_nxt;
    logic             t_nxt;

    // Next-state values shared by the debounce, edge and output registers, so that
    // evt, req and t all react on the same edge that stable is updated.
    always_comb begin
        accept     = (s2 != stable) && (cnt == DB_LAST);
        fall       = accept && stable;
        stable_nxt = accept ? s2 : stable;
        served     = (lt_s == 3'b001);
        req_nxt    = req;
        if (served) begin
            req_nxt = 1'b0;
        end else if (fall) begin
            req_nxt = 1'b1;
        end
        t_nxt = (LATCH != 0) ? (req_nxt | ~stable_nxt) : ~stable_nxt;
    end

    // Two-flop synchronizers for the raw pin and the slow-clock light bus.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1    <= 1'b1;
            s2    <= 1'b1;
            lt_s1 <= 3'b100;
            lt_s  <= 3'b100;
        end else begin
            s1    <= pin_n;
            s2    <= s1;
            lt_s1 <= lt;
            lt_s  <= lt_s1;
        end
    end

    // Debounce: a new level is accepted only after DB_CYCLES consecutive differing samples.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stable <= 1'b1;
            cnt    <= '0;
        end else if (s2 == stable) begin
            cnt <= '0;
        end else if (accept) begin
            stable <= s2;
            cnt    <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    // Press pulse, served-aware request latch, output level and saturating press count.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            evt   <= 1'b0;
            req   <= 1'b0;
            t     <= 1'b0;
            count <= 8'h00;
        end else begin
            evt <= fall;
            req <= req_nxt;
            t   <= t_nxt;
            if (evt && (count != 8'hFF)) begin
                count <= count + 8'd1;
            end
        end
    end

endmodule

module traffic_sensor_in #(
    parameter int DB_CYCLES = 40000,
    parameter int CNT_W     = 16,
    parameter int LATCH     = 1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       pin_ta_n,
    input  logic       pin_tb_n,
    input  logic [2:0] la,
    input  logic [2:0] lb,
    output logic       ta,
    output logic       tb,
    output logic       ta_evt,
    output logic       tb_evt,
    output logic [7:0] a_count,
    output logic [7:0] b_count
);

    traffic_sensor_chan #(
        .DB_CYCLES (DB_CYCLES),
        .CNT_W     (CNT_W),
        .LATCH     (LATCH)
    ) u_chan_a (
        .clk   (clk),
        .reset (reset),
        .pin_n (pin_ta_n),
        .lt    (la),
        .t     (ta),
        .evt   (ta_evt),
        .count (a_count)
    );

    traffic_sensor_chan #(
        .DB_CYCLES (DB_CYCLES),
        .CNT_W     (CNT_W),
        .LATCH     (LATCH)
    ) u_chan_b (
        .clk   (clk),
        .reset (reset),
        .pin_n (pin_tb_n),
        .lt    (lb),
        .t     (tb),
        .evt   (tb_evt),
        .count (b_count)
    );

endmodule

// File: tb/tb_traffic_sensor_in.sv
// tb/tb_traffic_sensor_in.sv - self-checking bench for traffic_sensor_in
module tb_traffic_sensor_in;

    localparam int DB = 4;

    logic       clk;
    logic       reset;
    logic       pin_ta_n;
    logic       pin_tb_n;
    logic [2:0] la;
    logic [2:0] lb;

    logic       ta, tb, ta_evt, tb_evt;
    logic [7:0] a_count, b_count;
    logic       ta0, tb0, ta_evt0, tb_evt0;
    logic [7:0] a_count0, b_count0;

    int checks = 0;
    int errors = 0;

    traffic_sensor_in #(.DB_CYCLES(DB), .CNT_W(16), .LATCH(1)) dut (
        .clk      (clk),
        .reset    (reset),
        .pin_ta_n (pin_ta_n),
        .pin_tb_n (pin_tb_n),
        .la       (la),
        .lb       (lb),
        .ta       (ta),
        .tb       (tb),
        .ta_evt   (ta_evt),
        .tb_evt   (tb_evt),
        .a_count  (a_count),
        .b_count  (b_count)
    );

    traffic_sensor_in #(.DB_CYCLES(DB), .CNT_W(16), .LATCH(0)) dut0 (
        .clk      (clk),
        .reset    (reset),
        .pin_ta_n (pin_ta_n),
        .pin_tb_n (pin_tb_n),
        .la       (la),
        .lb       (lb),
        .ta       (ta0),
        .tb       (tb0),
        .ta_evt   (ta_evt0),
        .tb_evt   (tb_evt0),
        .a_count  (a_count0),
        .b_count  (b_count0)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Behavioural model: per street, samples reach the debouncer two edges late; a new
    // level is taken once it has been observed DB edges in a row.
    bit         pd1[2], pd2[2], st[2], evt_m[2], req_m[2], tal_m[2], tan_m[2];
    int         run[2];
    int         cnt_m[2];
    logic [2:0] ld1[2], ld2[2];

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int s = 0; s < 2; s++) begin
                pd1[s] = 1'b1; pd2[s] = 1'b1; st[s] = 1'b1;
                evt_m[s] = 1'b0; req_m[s] = 1'b0; tal_m[s] = 1'b0; tan_m[s] = 1'b0;
                run[s] = 0; cnt_m[s] = 0;
                ld1[s] = 3'b100; ld2[s] = 3'b100;
            end
        end else begin
            for (int s = 0; s < 2; s++) begin
                bit obs;
                bit fall;
                bit green;
                obs   = pd2[s];
                green = (ld2[s] == 3'b001);
                fall  = 1'b0;
                if (evt_m[s] && cnt_m[s] < 255) cnt_m[s] = cnt_m[s] + 1;
                if (obs != st[s]) begin
                    run[s] = run[s] + 1;
                    if (run[s] == DB) begin
                        fall   = st[s];
                        st[s]  = obs;
                        run[s] = 0;
                    end
                end else begin
                    run[s] = 0;
                end
                evt_m[s] = fall;
                if (green) req_m[s] = 1'b0;
                else if (fall) req_m[s] = 1'b1;
                tal_m[s] = req_m[s] | ~st[s];
                tan_m[s] = ~st[s];
                pd2[s] = pd1[s];
                pd1[s] = (s == 0) ? pin_ta_n : pin_tb_n;
                ld2[s] = ld1[s];
                ld1[s] = (s == 0) ? la : lb;
            end
        end
    end

    // Cycle-by-cycle comparison of both instances against the model.
    always @(negedge clk) begin
        if (!reset) begin
            chk("ta",       ta,       tal_m[0]);
            chk("tb",       tb,       tal_m[1]);
            chk("ta_evt",   ta_evt,   evt_m[0]);
            chk("tb_evt",   tb_evt,   evt_m[1]);
            chk("a_count",  a_count,  cnt_m[0]);
            chk("b_count",  b_count,  cnt_m[1]);
            chk("ta_nl",    ta0,      tan_m[0]);
            chk("tb_nl",    tb0,      tan_m[1]);
            chk("ta_evt_nl", ta_evt0, evt_m[0]);
            chk("a_count_nl", a_count0, cnt_m[0]);
        end
    end

    initial begin
        reset    = 1'b1;
        pin_ta_n = 1'b1;
        pin_tb_n = 1'b1;
        la       = 3'b100;
        lb       = 3'b100;
        step(2);
        chk("rst_ta", ta, 0);
        chk("rst_tb", tb, 0);
        chk("rst_evt", ta_evt, 0);
        chk("rst_cnt", a_count, 0);
        reset = 1'b0;
        step(3);

        // Short bounces never reach the debounce threshold.
        repeat (5) begin
            pin_ta_n = 1'b0;
            step(3);
            pin_ta_n = 1'b1;
            step(3);
        end
        chk("t2_ta", ta, 0);
        chk("t2_cnt", a_count, 0);
        step(4);

        // Held press: ta and ta_evt rise on edge DB+2 after the first sampling edge.
        pin_ta_n = 1'b0;
        for (int k = 1; k <= DB + 2; k++) begin
            step(1);
            if (k == DB + 1) chk("t1_ta_early", ta, 0);
            if (k == DB + 2) begin
                chk("t1_ta_rise", ta, 1);
                chk("t1_evt_rise", ta_evt, 1);
            end
        end
        step(1);
        chk("t1_evt_one", ta_evt, 0);
        chk("t1_cnt", a_count, 1);
        chk("t1_tb", tb, 0);
        step(3);

        // Release under red keeps the request; green clears it three edges later.
        pin_ta_n = 1'b1;
        step(10);
        chk("t3_latched", ta, 1);
        chk("t3_nolatch", ta0, 0);
        la = 3'b001;
        step(2);
        chk("t3_green2", ta, 1);
        step(1);
        chk("t3_green3", ta, 0);
        la = 3'b100;
        step(5);
        chk("t3_red_after", ta, 0);

        // Non-latching instance follows the debounced level; green with a press keeps ta high.
        pin_ta_n = 1'b0;
        step(DB + 1);
        chk("t4_pre", ta0, 0);
        step(1);
        chk("t4_rise", ta0, 1);
        la = 3'b001;
        step(10);
        chk("t4_green_nl", ta0, 1);
        chk("t4_green_l", ta, 1);
        pin_ta_n = 1'b1;
        step(DB + 1);
        chk("t4_hold", ta0, 1);
        step(1);
        chk("t4_fall", ta0, 0);
        chk("t4_fall_l", ta, 0);
        la = 3'b100;
        step(4);

        // Many simultaneous A/B presses: counters saturate and never wrap.
        for (int i = 0; i < 300; i++) begin
            pin_ta_n = 1'b0;
            pin_tb_n = 1'b0;
            step(DB + 3);
            pin_ta_n = 1'b1;
            pin_tb_n = 1'b1;
            step(DB + 3);
        end
        step(4);
        chk("t5_a_sat", a_count, 8'hFF);
        chk("t5_b_sat", b_count, 8'hFF);
        chk("t5_ta_req", ta, 1);

        // Reset mid-debounce with a pending request clears everything at once.
        pin_ta_n = 1'b0;
        step(4);
        #2 reset = 1'b1;
        #1;
        chk("t6_ta", ta, 0);
        chk("t6_tb", tb, 0);
        chk("t6_evt", ta_evt, 0);
        chk("t6_acnt", a_count, 0);
        chk("t6_bcnt", b_count, 0);
        @(posedge clk);
        #1 reset = 1'b0;
        for (int k = 1; k <= DB + 2; k++) begin
            step(1);
            if (k == DB + 1) chk("t6_early", ta, 0);
            if (k == DB + 2) chk("t6_rise", ta, 1);
        end
        step(2);
        chk("t6_cnt", a_count, 1);
        pin_ta_n = 1'b1;
        step(10);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
